lc3_multicycle_core: RTL and testbench
======================================

Name: lc3_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle LC-3 datapath.
- Fetches, decodes and executes LC-3 instructions through an internal FSM over a single shared memory port with a req/ready handshake, so memory may insert wait states.
- Generalises data/address width and reset PC, and adds NZP condition codes, conditional branch, JSR/JSRR and halt-on-TRAP.
- Sits between the top-level and the unified RAM.

Parameters:
- DATA_W, 16: register, ALU, PC and memory data/address width; must be ≥16. Instructions are the low 16 bits of a fetched word.
- RESET_PC, 16'h3000: PC value loaded on reset; zero-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  DATA_W  transaction address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  completes the current transaction
- pc  out  DATA_W  current PC
- cc  out  3  {N,Z,P}
- halted  out  1  high once TRAP has executed
- illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (already decided): one clock `clk`; `rst` is synchronous, active-high.
  - On rst: PC=RESET_PC, R0–R7=0, IR=0, cc=3'b010, state=FETCH, mem_req=0, mem_we=0, halted=0, illegal=0.
  - A transaction in flight when rst asserts is abandoned; mem_req is low the cycle after.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ready=1.
  - The transaction completes in that cycle; mem_rdata is sampled at that edge; mem_req drops the next cycle.
  - mem_ready while mem_req=0 is ignored. Zero-wait memory (ready tied high) completes in the request cycle.
- States: FETCH → DECODE → EXEC → (MEM) → FETCH; HALT is absorbing.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready: IR ← mem_rdata[15:0], PC ← PC+1 (mod 2^DATA_W).
- DECODE: reads SR1=IR[8:6] and SR2=IR[2:0]. ST/STR source register is IR[11:9].
- EXEC: ALU ops write DR=IR[11:9]; address ops compute EA. PC-relative offsets use the already-incremented PC. All immediates/offsets are sign-extended to DATA_W; arithmetic wraps mod 2^DATA_W.
  - ADD/AND (0001/0101): IR[5] selects imm5 or SR2.
  - NOT (1001): DR ← ~SR1.
  - BR (0000): PC ← PC+off9 if (IR[11:9] & cc) ≠ 0. BR with nzp=000 is a NOP.
  - JMP (1100): PC ← SR1 (RET included).
  - JSR/JSRR (0100): R7 ← PC. Target is PC+off11 (IR[11]=1) or the SR1 value read before the R7 write, so JSRR R7 is well defined.
  - LEA (1110): DR ← PC+off9; cc unchanged.
  - LD/ST (0010/0011): EA = PC+off9.
  - LDR/STR (0110/0111): EA = SR1+off6. All four go to MEM.
  - TRAP (1111): → HALT. PC keeps its incremented value; halted=1 until rst.
  - RTI, LDI, STI, reserved (1000/1010/1011/1101): illegal pulses for one cycle in EXEC; otherwise NOP.
- MEM: mem_addr=EA.
  - Loads write DR when ready.
  - Stores drive mem_we=1 and mem_wdata = the IR[11:9] register.
- Condition codes: updated from the written value on ADD, AND, NOT, LD, LDR only. N = MSB, Z = all-zero, P = otherwise.
- Register writes occur at the EXEC/MEM exit edge. A JSR writing R7 and a following read of R7 see the new value.
- Latency with zero-wait memory: ALU/branch/jump = 3 cycles; load/store = 4; each wait cycle adds 1.

Test Plan:
- Reset, RESET_PC=16'h3000, zero-wait → first FETCH drives mem_req=1, mem_addr=0x3000; cc=010; halted=0.
- IR=0x127F (ADD R1,R1,#-1), R1=0 → R1=0xFFFF, cc=100 after 3 cycles; DATA_W=32 build gives R1=0xFFFFFFFF.
- IR=0x0402 (BRz #2) at 0x3000 with cc=010 → next fetch addr 0x3003; with cc=001 → 0x3001.
- IR=0x2005 (LD R0,#5) at 0x3000, mem_ready low 3 cycles in MEM → mem_addr=0x3006 held stable 4 cycles, R0=rdata, cc updated, total 7 cycles.
- R7=0x4000, IR=0x41C0 (JSRR R7) at 0x3010 → PC=0x4000, R7=0x3011. Then IR=0x74FE (STR R2,R3,#-2), R3=0x5000, R2=0xBEEF → write addr 0x4FFE, data 0xBEEF, mem_we=1.
- IR=0xF025 → halted=1, no further mem_req. Assert rst mid-LD wait → mem_req=0 next cycle, PC=0x3000, all registers 0.

Source files
------------

// File: rtl/lc3_multicycle_core.sv
// Multi-cycle LC-3 core: FETCH/DECODE/EXEC/MEM over one shared memory port.
// Handshake: mem_req/mem_we/mem_addr/mem_wdata are held from assertion until the cycle mem_ready=1; mem_rdata is sampled at that edge.
module lc3_multicycle_core #(
  parameter int          DATA_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic [2:0]        cc,
  output logic              halted,
  output logic              illegal
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7;
  localparam logic [3:0] OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] sr1_val, sr2_val;

  logic [3:0]        opcode;
  logic [2:0]        dr, wr_dst;
  logic [DATA_W-1:0] imm5, off6, off9, off11;
  logic [DATA_W-1:0] alu_res, next_pc, ea;
  logic              is_mem, is_store, is_illegal, writes_reg, sets_cc;

  function automatic logic [2:0] nzp(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1])  return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  always_comb begin
    opcode     = ir[15:12];
    dr         = ir[11:9];
    imm5       = DATA_W'($signed(ir[4:0]));
    off6       = DATA_W'($signed(ir[5:0]));
    off9       = DATA_W'($signed(ir[8:0]));
    off11      = DATA_W'($signed(ir[10:0]));
    alu_res    = '0;
    next_pc    = pc;
    ea         = '0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_illegal = 1'b0;
    writes_reg = 1'b0;
    sets_cc    = 1'b0;
    // pc already holds the incremented value here, so every PC-relative form uses it directly
    case (opcode)
      OP_ADD: begin
        alu_res    = sr1_val + (ir[5] ? imm5 : sr2_val);
        writes_reg = 1'b1;
        sets_cc    = 1'b1;
      end
      OP_AND: begin
        alu_res    = sr1_val & (ir[5] ? imm5 : sr2_val);
        writes_reg = 1'b1;
        sets_cc    = 1'b1;
      end
      OP_NOT: begin
        alu_res    = ~sr1_val;
        writes_reg = 1'b1;
        sets_cc    = 1'b1;
      end
      OP_BR:  if ((ir[11:9] & cc) != 3'b000) next_pc = pc + off9;
      OP_JMP: next_pc = sr1_val;
      OP_JSR: begin
        alu_res    = pc;
        writes_reg = 1'b1;
        next_pc    = ir[11] ? pc + off11 : sr1_val;
      end
      OP_LEA: begin
        alu_res    = pc + off9;
        writes_reg = 1'b1;
      end
      OP_LD, OP_ST: begin
        ea       = pc + off9;
        is_mem   = 1'b1;
        is_store = (opcode == OP_ST);
      end
      OP_LDR, OP_STR: begin
        ea       = sr1_val + off6;
        is_mem   = 1'b1;
        is_store = (opcode == OP_STR);
      end
      OP_RTI, OP_LDI, OP_STI, OP_RES: is_illegal = 1'b1;
      default: ;
    endcase
    wr_dst = (opcode == OP_JSR) ? 3'd7 : dr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= DATA_W'(RESET_PC);
      ir        <= '0;
      cc        <= 3'b010;
      sr1_val   <= '0;
      sr2_val   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_FETCH: begin
          // only the first fetch after reset arrives here without a request already raised
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir      <= mem_rdata[15:0];
            pc      <= pc + ONE;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          sr1_val <= regs[ir[8:6]];
          sr2_val <= regs[ir[2:0]];
          illegal <= is_illegal;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (opcode == OP_TRAP) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= ea;
            mem_wdata <= regs[dr];
            state     <= S_MEM;
          end else begin
            if (writes_reg) regs[wr_dst] <= alu_res;
            if (sets_cc)    cc <= nzp(alu_res);
            pc       <= next_pc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= next_pc;
            state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (!mem_we) begin
              regs[dr] <= mem_rdata;
              cc       <= nzp(mem_rdata);
            end
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end
        S_HALT: mem_req <= 1'b0;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_multicycle_core.sv
// Bench for lc3_multicycle_core: instruction-level LC-3 model predicts every memory transaction.
module tb_lc3_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  cc;
  logic        halted, illegal;

  always #5 clk = ~clk;

  lc3_multicycle_core #(.DATA_W(16), .RESET_PC(16'h3000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .cc(cc), .halted(halted), .illegal(illegal)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory images: the bench's RAM and the model's private copy
  logic [15:0] tb_mem [65536];
  logic [15:0] m_mem  [65536];

  // model state; exp_q entries are {is_fetch, we, addr, data}, fetch data = {lat_prev, cc_expected}
  logic [15:0] m_pc;
  logic [15:0] m_r [8];
  logic [2:0]  m_cc;
  bit          m_halted;
  int          m_ill, m_ill_prev, m_lat;
  logic [33:0] exp_q [$];
  logic [16:0] log_q [$];

  int          mode;      // 0 zero-wait, 1 random wait, 2 never ready
  int          cyc, last_fetch, nfetch, stop_at, tb_ill;
  bit          stop, pending;
  logic [32:0] held;
  logic [33:0] e;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic signed [15:0] t;
    t = $signed(v << (16 - bits));
    return t >>> (16 - bits);
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_step();
    logic [15:0] ins, npc, a, b, v, ea;
    logic [2:0]  d;
    ins        = m_mem[m_pc];
    m_ill_prev = m_ill;
    exp_q.push_back({1'b1, 1'b0, m_pc, 9'd0, 4'(m_lat), m_cc});
    npc   = m_pc + 16'd1;
    d     = ins[11:9];
    a     = m_r[ins[8:6]];
    b     = m_r[ins[2:0]];
    m_lat = 3;
    case (ins[15:12])
      4'h1: begin v = a + (ins[5] ? sx(ins, 5) : b); m_r[d] = v; m_cc = nzp_of(v); end
      4'h5: begin v = a & (ins[5] ? sx(ins, 5) : b); m_r[d] = v; m_cc = nzp_of(v); end
      4'h9: begin v = ~a; m_r[d] = v; m_cc = nzp_of(v); end
      4'h0: if ((ins[11:9] & m_cc) != 3'b000) npc = npc + sx(ins, 9);
      4'hC: npc = a;
      4'h4: begin v = ins[11] ? npc + sx(ins, 11) : a; m_r[7] = npc; npc = v; end
      4'hE: m_r[d] = npc + sx(ins, 9);
      4'h2, 4'h6: begin
        ea = (ins[15:12] == 4'h2) ? npc + sx(ins, 9) : a + sx(ins, 6);
        exp_q.push_back({1'b0, 1'b0, ea, 16'h0});
        v = m_mem[ea]; m_r[d] = v; m_cc = nzp_of(v); m_lat = 4;
      end
      4'h3, 4'h7: begin
        ea = (ins[15:12] == 4'h3) ? npc + sx(ins, 9) : a + sx(ins, 6);
        exp_q.push_back({1'b0, 1'b1, ea, m_r[d]});
        m_mem[ea] = m_r[d]; m_lat = 4;
      end
      4'hF: m_halted = 1'b1;
      default: m_ill++;
    endcase
    m_pc = npc;
  endtask

  // memory responder and transaction monitor, all on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      case (mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 2) != 0);
        default: mem_ready = 1'b0;
      endcase
      mem_rdata = tb_mem[mem_addr];
      if (illegal) tb_ill++;
      if (mem_req) begin
        if (pending) check("hold_stable", {mem_we, mem_addr, mem_wdata}, held);
        pending = !mem_ready;
        held    = {mem_we, mem_addr, mem_wdata};
        if (mem_ready) begin
          if (exp_q.size() == 0 && !m_halted) model_step();
          log_q.push_back({mem_we, mem_addr});
          check("txn_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("txn_addr", mem_addr, e[31:16]);
            check("txn_we", mem_we, e[32]);
            if (e[32]) check("txn_wdata", mem_wdata, e[15:0]);
            if (e[33]) begin
              check("fetch_cc", cc, e[2:0]);
              check("fetch_pc", pc, e[31:16]);
              if (mode == 0 && e[6:3] != 4'd0) check("latency", cyc - last_fetch, e[6:3]);
              last_fetch = cyc;
              nfetch++;
              if (nfetch == stop_at) begin
                check("illegal_count", tb_ill, m_ill_prev);
                stop = 1'b1;
              end
            end
          end
          if (mem_we) tb_mem[mem_addr] = mem_wdata;
        end
      end
    end
  end

  task automatic fill_random();
    logic [3:0] ops [16] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h4, 4'hE, 4'h2,
                             4'h6, 4'h3, 4'h7, 4'h8, 4'hA, 4'h1, 4'h5, 4'h0};
    for (int a = 0; a < 65536; a++) tb_mem[a] = {ops[$urandom_range(0, 15)], 12'($urandom)};
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_pc", pc, 16'h3000);
    check("rst_cc", cc, 3'b010);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    m_mem = tb_mem;
    m_pc = 16'h3000; m_cc = 3'b010; m_halted = 1'b0; m_ill = 0; m_ill_prev = 0; m_lat = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    exp_q.delete(); log_q.delete();
    cyc = 0; last_fetch = 0; nfetch = 0; tb_ill = 0; stop = 1'b0; pending = 1'b0; stop_at = 0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic run_prog(input int md, input int n, input int bound);
    int req_cnt;
    mode = md; stop_at = n;
    for (int i = 0; i < bound && !stop && !(m_halted && exp_q.size() == 0); i++) @(negedge clk);
    check("run_done", stop || m_halted, 1);
    if (m_halted && !stop) begin
      req_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_req) req_cnt++;
      end
      check("halt_no_req", req_cnt, 0);
      check("halted", halted, 1);
      check("halt_pc", pc, m_pc);
    end
  endtask

  logic [16:0] tab1 [7]  = '{17'h03000, 17'h03001, 17'h03002, 17'h03003, 17'h03006, 17'h0300C, 17'h03007};
  logic [16:0] tab2 [10] = '{17'h03000, 17'h03006, 17'h03001, 17'h03007, 17'h03002, 17'h03008,
                             17'h03003, 17'h04000, 17'h14FFE, 17'h04001};

  initial begin
    mode = 0; mem_ready = 1'b0; mem_rdata = 16'h0;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ADD/AND/BR/LD then TRAP, zero-wait
    fill_random();
    tb_mem[16'h3000] = 16'h127F; tb_mem[16'h3001] = 16'h0402; tb_mem[16'h3002] = 16'h5260;
    tb_mem[16'h3003] = 16'h0402; tb_mem[16'h3006] = 16'h2005; tb_mem[16'h3007] = 16'hF025;
    tb_mem[16'h300C] = 16'h8001;
    apply_reset();
    run_prog(0, 1000, 2000);
    check("d1_log_len", log_q.size(), 7);
    for (int i = 0; i < 7 && i < log_q.size(); i++) check("d1_log", log_q[i], tab1[i]);
    check("d1_halt_pc", pc, 16'h3008);
    check("d1_halt_cc", cc, 3'b100);

    // LD setup, JSRR R7, STR R2,R3,#-2, random waits
    fill_random();
    tb_mem[16'h3000] = 16'h2E05; tb_mem[16'h3001] = 16'h2605; tb_mem[16'h3002] = 16'h2405;
    tb_mem[16'h3003] = 16'h41C0; tb_mem[16'h3006] = 16'h4000; tb_mem[16'h3007] = 16'h5000;
    tb_mem[16'h3008] = 16'hBEEF; tb_mem[16'h4000] = 16'h74FE; tb_mem[16'h4001] = 16'hF025;
    apply_reset();
    run_prog(1, 1000, 3000);
    check("d2_log_len", log_q.size(), 10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) check("d2_log", log_q[i], tab2[i]);
    check("d2_str_data", tb_mem[16'h4FFE], 16'hBEEF);

    // reset while an LD waits in MEM
    fill_random();
    tb_mem[16'h3000] = 16'h2005;
    apply_reset();
    mode = 0; stop_at = 1000;
    for (int i = 0; i < 50 && nfetch < 1; i++) @(posedge clk);
    mode = 2;
    repeat (5) @(negedge clk);
    check("ld_wait_req", mem_req, 1);
    check("ld_wait_addr", mem_addr, 16'h3006);
    check("ld_wait_we", mem_we, 0);
    // after reset every register must read back as zero through stores
    for (int i = 0; i < 8; i++) tb_mem[16'h3000 + i] = 16'h7000 | 16'(i << 9) | 16'(i);
    tb_mem[16'h3008] = 16'hF025;
    apply_reset();
    run_prog(1, 1000, 3000);
    for (int i = 0; i < 8; i++) check("zero_reg", tb_mem[i], 16'h0);

    // random programs, alternating zero-wait and random-wait memory
    for (int r = 0; r < 6; r++) begin
      fill_random();
      apply_reset();
      run_prog(r % 2, 250, 6000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
